elpis_mem_loader: RTL and testbench

Sequencing controller that loads a program image into the Elpis core memory and then releases the core to run. Sits between the host-side logic-analyzer/Wishbone glue and the Elpis core's memory-load port. Holds the core in reset while streaming host-supplied words into consecutive memory addresses, then releases reset after a fixed guard interval. Handles restart and address-overflow errors.

---
 rtl/elpis_loader_pkg.sv | 17 +
 rtl/elpis_cycle_timer.sv | 28 ++
 rtl/elpis_mem_loader.sv | 143 ++++++++++++++
 tb/tb_elpis_mem_loader.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elpis_loader_pkg.sv
// Shared definitions for the Elpis memory loader: FSM state encoding and
// default memory geometry.
package elpis_loader_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    LDR_IDLE    = 3'd0,
    LDR_LOAD    = 3'd1,
    LDR_WRITE   = 3'd2,
    LDR_RELEASE = 3'd3,
    LDR_RUN     = 3'd4,
    LDR_ERROR   = 3'd5
  } loader_state_e;

endpackage

// File: rtl/elpis_cycle_timer.sv
// Loadable down-counter with a zero flag. Times both the per-word write
// strobe and the post-load reset guard interval.
module elpis_cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over counting; the counter parks at zero until reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/elpis_mem_loader.sv
// Elpis program loader: holds the core in reset, streams host words into
// consecutive memory addresses, then releases the core after a guard time.
module elpis_mem_loader
  import elpis_loader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int WR_CYCLES  = 2,
  parameter int RESET_HOLD = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              host_start,
  input  logic [ADDR_W-1:0] host_base_addr,
  input  logic              host_word_valid,
  input  logic [DATA_W-1:0] host_word,
  input  logic              host_last,
  output logic              host_word_ready,
  output logic              core_reset,
  output logic              is_loading_memory_into_core,
  output logic              core_mem_we,
  output logic [ADDR_W-1:0] addr_to_core_mem,
  output logic [DATA_W-1:0] data_to_core_mem,
  output logic [ADDR_W:0]   word_count,
  output logic              host_done,
  output logic              load_error
);

  localparam logic [2:0] S_IDLE    = LDR_IDLE;
  localparam logic [2:0] S_LOAD    = LDR_LOAD;
  localparam logic [2:0] S_WRITE   = LDR_WRITE;
  localparam logic [2:0] S_RELEASE = LDR_RELEASE;
  localparam logic [2:0] S_RUN     = LDR_RUN;
  localparam logic [2:0] S_ERROR   = LDR_ERROR;

  // Timer holds "cycles remaining minus one", so it must fit the larger
  // interval minus one.
  localparam int TMR_MAX = (WR_CYCLES > RESET_HOLD) ? WR_CYCLES : RESET_HOLD;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] WR_LOAD   = TMR_W'(WR_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(RESET_HOLD - 1);

  localparam logic [ADDR_W:0] WC_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_zero;

  // Handshake: a word transfers on a rising edge where host_word_valid and
  // host_word_ready are both high. ready is decoded from state only, so a
  // host_start in the same cycle overrides the transfer (word is dropped and
  // must be re-presented after the restart).
  logic accept;
  assign accept = (state == S_LOAD) && host_word_valid && !host_start;

  // Timer reload points: word accept starts the write strobe, the final
  // write of the last word starts the reset guard.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = WR_LOAD;
    if (accept) begin
      tmr_load = 1'b1;
      tmr_val  = WR_LOAD;
    end else if (!host_start && (state == S_WRITE) && tmr_zero && last_q) begin
      tmr_load = 1'b1;
      tmr_val  = HOLD_LOAD;
    end
  end

  elpis_cycle_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Sequencer FSM with address/data/count registers; host_start overrides all.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      word_count <= '0;
    end else if (host_start) begin
      state      <= S_LOAD;
      addr_q     <= host_base_addr;
      word_count <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (host_word_valid) begin
            data_q <= host_word;
            last_q <= host_last;
            state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (tmr_zero) begin
            if (word_count != WC_MAX) begin
              word_count <= word_count + 1'b1;
            end
            if (last_q) begin
              state <= S_RELEASE;
            end else if (addr_q == '1) begin
              // No wrap: the next word would fall off the top of memory.
              state <= S_ERROR;
            end else begin
              addr_q <= addr_q + 1'b1;
              state  <= S_LOAD;
            end
          end
        end
        S_RELEASE: begin
          if (tmr_zero) begin
            state <= S_RUN;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  // All outputs decode from registered state.
  assign host_word_ready             = (state == S_LOAD);
  assign core_reset                  = (state != S_RUN);
  assign is_loading_memory_into_core = (state == S_LOAD) || (state == S_WRITE);
  assign core_mem_we                 = (state == S_WRITE);
  assign addr_to_core_mem            = addr_q;
  assign data_to_core_mem            = data_q;
  assign host_done                   = (state == S_RUN);
  assign load_error                  = (state == S_ERROR);

endmodule

// File: tb/tb_elpis_mem_loader.sv
// Self-checking bench for elpis_mem_loader (default parameters).
module tb_elpis_mem_loader;

  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          host_start;
  logic [AW-1:0] host_base_addr;
  logic          host_word_valid;
  logic [DW-1:0] host_word;
  logic          host_last;
  logic          host_word_ready;
  logic          core_reset;
  logic          is_loading;
  logic          core_mem_we;
  logic [AW-1:0] addr_to_core_mem;
  logic [DW-1:0] data_to_core_mem;
  logic [AW:0]   word_count;
  logic          host_done;
  logic          load_error;

  int checks;
  int failures;

  elpis_mem_loader dut (
    .wb_clk_i                    (clk),
    .wb_rst_i                    (rst),
    .host_start                  (host_start),
    .host_base_addr              (host_base_addr),
    .host_word_valid             (host_word_valid),
    .host_word                   (host_word),
    .host_last                   (host_last),
    .host_word_ready             (host_word_ready),
    .core_reset                  (core_reset),
    .is_loading_memory_into_core (is_loading),
    .core_mem_we                 (core_mem_we),
    .addr_to_core_mem            (addr_to_core_mem),
    .data_to_core_mem            (data_to_core_mem),
    .word_count                  (word_count),
    .host_done                   (host_done),
    .load_error                  (load_error)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          start;
    logic [AW-1:0] base;
    logic          valid;
    logic [DW-1:0] word;
    logic          last;
    logic          e_ready;
    logic          e_we;
    logic          e_load;
    logic          e_reset;
    logic          e_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [AW:0]   e_cnt;
  } vec_t;

  vec_t vecs[14];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] bp_words[5];

  function automatic vec_t mk(input logic st, input logic [AW-1:0] b, input logic v,
                              input logic [DW-1:0] w, input logic l,
                              input logic r, input logic we, input logic ld,
                              input logic rs, input logic dn, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [AW:0] c);
    vec_t t;
    t.start = st; t.base = b; t.valid = v; t.word = w; t.last = l;
    t.e_ready = r; t.e_we = we; t.e_load = ld; t.e_reset = rs; t.e_done = dn;
    t.e_addr = a; t.e_data = d; t.e_cnt = c;
    return t;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 64'(host_word_ready), 64'd0);
    check({tag, "_reset"}, 64'(core_reset), 64'd1);
    check({tag, "_load"},  64'(is_loading), 64'd0);
    check({tag, "_we"},    64'(core_mem_we), 64'd0);
    check({tag, "_addr"},  64'(addr_to_core_mem), 64'd0);
    check({tag, "_data"},  64'(data_to_core_mem), 64'd0);
    check({tag, "_cnt"},   64'(word_count), 64'd0);
    check({tag, "_done"},  64'(host_done), 64'd0);
    check({tag, "_err"},   64'(load_error), 64'd0);
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!host_done && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 64'(host_done), 64'd1);
    check({tag, "_reset_low"}, 64'(core_reset), 64'd0);
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    host_start = 1'b1;
    host_base_addr = base;
    tick();
    host_start = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input logic l);
    host_word_valid = 1'b1;
    host_word = w;
    host_last = l;
    tick();
    host_word_valid = 1'b0;
    host_last = 1'b0;
  endtask

  // Stimulus and scoreboard
  initial begin
    logic [DW-1:0] wa, wb, wc;
    int idx;
    logic prev_we;
    logic acc;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    host_start = 1'b0;
    host_base_addr = '0;
    host_word_valid = 1'b0;
    host_word = '0;
    host_last = 1'b0;

    wa = 32'hA0A0_0001;
    wb = 32'hB0B0_0002;
    wc = 32'hC0C0_0003;

    // Basic load at 0x10: three words, valid held high throughout.
    vecs[0]  = mk(1, 20'h00010, 0, 0,  0,  1, 0, 1, 1, 0, 20'h00010, 0,  0);
    vecs[1]  = mk(0, 0,         1, wa, 0,  0, 1, 1, 1, 0, 20'h00010, wa, 0);
    vecs[2]  = mk(0, 0,         1, wb, 0,  0, 1, 1, 1, 0, 20'h00010, wa, 0);
    vecs[3]  = mk(0, 0,         1, wb, 0,  1, 0, 1, 1, 0, 20'h00011, wa, 1);
    vecs[4]  = mk(0, 0,         1, wb, 0,  0, 1, 1, 1, 0, 20'h00011, wb, 1);
    vecs[5]  = mk(0, 0,         1, wc, 1,  0, 1, 1, 1, 0, 20'h00011, wb, 1);
    vecs[6]  = mk(0, 0,         1, wc, 1,  1, 0, 1, 1, 0, 20'h00012, wb, 2);
    vecs[7]  = mk(0, 0,         1, wc, 1,  0, 1, 1, 1, 0, 20'h00012, wc, 2);
    vecs[8]  = mk(0, 0,         0, 0,  0,  0, 1, 1, 1, 0, 20'h00012, wc, 2);
    vecs[9]  = mk(0, 0,         0, 0,  0,  0, 0, 0, 1, 0, 20'h00012, wc, 3);
    vecs[10] = mk(0, 0,         0, 0,  0,  0, 0, 0, 1, 0, 20'h00012, wc, 3);
    vecs[11] = mk(0, 0,         0, 0,  0,  0, 0, 0, 1, 0, 20'h00012, wc, 3);
    vecs[12] = mk(0, 0,         0, 0,  0,  0, 0, 0, 1, 0, 20'h00012, wc, 3);
    vecs[13] = mk(0, 0,         0, 0,  0,  0, 0, 0, 0, 1, 20'h00012, wc, 3);

    bp_words[0] = 32'h1111_0000;
    bp_words[1] = 32'h2222_0001;
    bp_words[2] = 32'h3333_0002;
    bp_words[3] = 32'h4444_0003;
    bp_words[4] = 32'h5555_0004;

    // Reset
    tick();
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");
    tick();
    check_idle("idle_hold");

    // Table-driven basic load
    for (int i = 0; i < 14; i++) begin
      host_start      = vecs[i].start;
      host_base_addr  = vecs[i].base;
      host_word_valid = vecs[i].valid;
      host_word       = vecs[i].word;
      host_last       = vecs[i].last;
      tick();
      check($sformatf("v%0d_ready", i), 64'(host_word_ready), 64'(vecs[i].e_ready));
      check($sformatf("v%0d_we", i),    64'(core_mem_we), 64'(vecs[i].e_we));
      check($sformatf("v%0d_load", i),  64'(is_loading), 64'(vecs[i].e_load));
      check($sformatf("v%0d_reset", i), 64'(core_reset), 64'(vecs[i].e_reset));
      check($sformatf("v%0d_done", i),  64'(host_done), 64'(vecs[i].e_done));
      check($sformatf("v%0d_addr", i),  64'(addr_to_core_mem), 64'(vecs[i].e_addr));
      check($sformatf("v%0d_data", i),  64'(data_to_core_mem), 64'(vecs[i].e_data));
      check($sformatf("v%0d_cnt", i),   64'(word_count), 64'(vecs[i].e_cnt));
      check($sformatf("v%0d_err", i),   64'(load_error), 64'd0);
    end
    host_start = 1'b0;
    host_word_valid = 1'b0;
    host_last = 1'b0;

    // Reload from RUN, then back-pressured stream of 5 words at 0x200
    do_start(20'h00200);
    check("reload_reset", 64'(core_reset), 64'd1);
    check("reload_done", 64'(host_done), 64'd0);
    check("reload_cnt", 64'(word_count), 64'd0);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(bp_words[k]);
      exp_addr_q.push_back(20'h00200 + AW'(k));
    end
    idx = 0;
    prev_we = 1'b0;
    for (int k = 0; k < 15; k++) begin
      check($sformatf("bp%0d_ready", k), 64'(host_word_ready), 64'((k % 3) == 0));
      if (core_mem_we && !prev_we) begin
        if (exp_q.size() == 0) begin
          check($sformatf("bp%0d_extra_write", k), 64'd1, 64'd0);
        end else begin
          check($sformatf("bp%0d_wr_data", k), 64'(data_to_core_mem), 64'(exp_q.pop_front()));
          check($sformatf("bp%0d_wr_addr", k), 64'(addr_to_core_mem), 64'(exp_addr_q.pop_front()));
        end
      end
      prev_we = core_mem_we;
      host_word_valid = 1'b1;
      host_word = bp_words[(idx < 5) ? idx : 4];
      host_last = (idx == 4);
      acc = host_word_ready && (idx < 5);
      host_word_valid = (idx < 5);
      tick();
      if (acc) idx++;
    end
    host_word_valid = 1'b0;
    host_last = 1'b0;
    check("bp_cnt", 64'(word_count), 64'd5);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    wait_done("bp", 10);

    // Overflow at top address
    do_start(20'hFFFFF);
    check("ovf_ready", 64'(host_word_ready), 64'd1);
    check("ovf_addr0", 64'(addr_to_core_mem), 64'hFFFFF);
    send_word(32'hDEAD_0001, 1'b0);
    check("ovf_we", 64'(core_mem_we), 64'd1);
    check("ovf_wr_addr", 64'(addr_to_core_mem), 64'hFFFFF);
    check("ovf_wr_data", 64'(data_to_core_mem), 64'hDEAD_0001);
    tick();
    check("ovf_we2", 64'(core_mem_we), 64'd1);
    tick();
    check("ovf_err", 64'(load_error), 64'd1);
    check("ovf_we_off", 64'(core_mem_we), 64'd0);
    check("ovf_reset", 64'(core_reset), 64'd1);
    check("ovf_load", 64'(is_loading), 64'd0);
    check("ovf_cnt", 64'(word_count), 64'd1);
    check("ovf_nowrap", 64'(addr_to_core_mem), 64'hFFFFF);
    tick();
    tick();
    tick();
    check("ovf_sticky", 64'(load_error), 64'd1);
    check("ovf_sticky_ready", 64'(host_word_ready), 64'd0);
    do_start(20'hFFFFF);
    check("ovf_clear", 64'(load_error), 64'd0);
    check("ovf_clear_cnt", 64'(word_count), 64'd0);
    // A last word at the top address is legal
    send_word(32'hBEEF_0002, 1'b1);
    tick();
    tick();
    check("top_last_err", 64'(load_error), 64'd0);
    check("top_last_cnt", 64'(word_count), 64'd1);
    wait_done("top_last", 10);

    // Restart mid-WRITE
    do_start(20'h00050);
    send_word(32'hF00D_0001, 1'b0);
    check("rs_we1", 64'(core_mem_we), 64'd1);
    check("rs_addr1", 64'(addr_to_core_mem), 64'h00050);
    host_start = 1'b1;
    host_base_addr = 20'h00100;
    host_word_valid = 1'b1;
    host_word = 32'h0BAD_0BAD;
    tick();
    check("rs_we_drop", 64'(core_mem_we), 64'd0);
    check("rs_ready", 64'(host_word_ready), 64'd1);
    check("rs_cnt", 64'(word_count), 64'd0);
    check("rs_addr", 64'(addr_to_core_mem), 64'h00100);
    // Word offered together with host_start in LOAD is not taken
    tick();
    host_start = 1'b0;
    host_word_valid = 1'b0;
    check("rs_same_cycle_we", 64'(core_mem_we), 64'd0);
    check("rs_same_cycle_ready", 64'(host_word_ready), 64'd1);
    send_word(32'h1234_5678, 1'b0);
    check("rs_new_we", 64'(core_mem_we), 64'd1);
    check("rs_new_addr", 64'(addr_to_core_mem), 64'h00100);
    check("rs_new_data", 64'(data_to_core_mem), 64'h1234_5678);
    tick();
    tick();
    check("rs_new_cnt", 64'(word_count), 64'd1);
    check("rs_next_addr", 64'(addr_to_core_mem), 64'h00101);
    check("rs_next_ready", 64'(host_word_ready), 64'd1);

    // Reset mid-RELEASE
    send_word(32'h7777_7777, 1'b1);
    tick();
    tick();
    check("rr_release_we", 64'(core_mem_we), 64'd0);
    check("rr_release_reset", 64'(core_reset), 64'd1);
    check("rr_release_cnt", 64'(word_count), 64'd2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rr");
    for (int k = 0; k < 6; k++) tick();
    check("rr_hold_reset", 64'(core_reset), 64'd1);
    check("rr_hold_done", 64'(host_done), 64'd0);
    check("rr_hold_ready", 64'(host_word_ready), 64'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
